// File: rtl/conv_out_buf.sv
// Output buffer behind the convolution datapath: optional ReLU, signed saturation to
// OUT_W, frame tagging every CONV_N results, and a small FIFO that absorbs sink stalls.
module conv_out_buf #(
   parameter int unsigned ACC_W     = 20,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned LG_DEPTH  = 2,
   parameter int unsigned CONV_N    = 5,
   parameter int unsigned LG_CONV_N = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    s_valid_y,
   input  logic signed [ACC_W-1:0] s_data_y,
   output logic                    s_ready_y,
   output logic                    m_valid_z,
   output logic signed [OUT_W-1:0] m_data_z,
   output logic                    m_last_z,
   input  logic                    m_ready_z,
   input  logic                    relu_en,
   input  logic                    clear_ovf,
   output logic                    ovf_sticky,
   output logic                    frame_done,
   output logic [LG_DEPTH:0]       occupancy
);

   localparam int unsigned CNT_W = LG_DEPTH + 1;

   localparam logic signed [ACC_W-1:0]   SAT_MAX   = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
   localparam logic signed [ACC_W-1:0]   SAT_MIN   = ~SAT_MAX;
   localparam logic [CNT_W-1:0]          FULL_OCC  = CNT_W'(DEPTH);
   localparam logic [LG_CONV_N-1:0]      LAST_BEAT = LG_CONV_N'(CONV_N - 1);

   typedef struct packed {
      logic             last;
      logic             sat;
      logic [OUT_W-1:0] data;
   } entry_t;

   entry_t                 mem [DEPTH];
   entry_t                 head;
   entry_t                 wr_entry;

   logic [LG_DEPTH-1:0]    wr_ptr_q, wr_ptr_d;
   logic [LG_DEPTH-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       occ_q, occ_d;
   logic [LG_CONV_N-1:0]   beat_q, beat_d;
   logic                   ovf_q, ovf_d;
   logic                   done_q, done_d;

   logic signed [ACC_W-1:0] relu_v;
   logic                    push;
   logic                    pop;
   logic                    unused_head_sat;

   // Handshake flags come only from registered occupancy, so neither side sees the other combinationally.
   assign s_ready_y = (occ_q != FULL_OCC);
   assign m_valid_z = (occ_q != '0);
   assign push      = s_valid_y & s_ready_y;
   assign pop       = m_valid_z & m_ready_z;

   assign head            = mem[rd_ptr_q];
   assign unused_head_sat = head.sat;

   assign m_data_z   = m_valid_z ? $signed(head.data) : '0;
   assign m_last_z   = m_valid_z & head.last;
   assign ovf_sticky = ovf_q;
   assign frame_done = done_q;
   assign occupancy  = occ_q;

   // Result conditioning at push time: ReLU first, then clamp into OUT_W.
   always_comb begin
      relu_v   = s_data_y;
      wr_entry = '0;
      if (relu_en && s_data_y[ACC_W-1]) begin
         relu_v = '0;
      end
      wr_entry.last = (beat_q == LAST_BEAT);
      if (relu_v > SAT_MAX) begin
         wr_entry.data = SAT_MAX[OUT_W-1:0];
         wr_entry.sat  = 1'b1;
      end else if (relu_v < SAT_MIN) begin
         wr_entry.data = SAT_MIN[OUT_W-1:0];
         wr_entry.sat  = 1'b1;
      end else begin
         wr_entry.data = relu_v[OUT_W-1:0];
      end
   end

   // Storage is intentionally left out of reset; occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_entry;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         beat_q   <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         beat_q   <= beat_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   // Next-state: pointers wrap naturally at power-of-two DEPTH; beat index follows pushes only.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      beat_d   = beat_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;

      if (push) begin
         wr_ptr_d = wr_ptr_q + LG_DEPTH'(1);
         beat_d   = (beat_q == LAST_BEAT) ? '0 : beat_q + LG_CONV_N'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + LG_DEPTH'(1);
         done_d   = head.last;
      end

      if (push && !pop) begin
         occ_d = occ_q + CNT_W'(1);
      end else if (pop && !push) begin
         occ_d = occ_q - CNT_W'(1);
      end

      // A saturating push outranks a same-cycle clear.
      if (push && wr_entry.sat) begin
         ovf_d = 1'b1;
      end else if (clear_ovf) begin
         ovf_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_out_buf.sv
// Directed and randomized bench for conv_out_buf against a queue-based reference model.
module tb_conv_out_buf;

   localparam int unsigned ACC_W     = 20;
   localparam int unsigned OUT_W     = 16;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned LG_DEPTH  = 2;
   localparam int unsigned CONV_N    = 5;
   localparam int unsigned LG_CONV_N = 3;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    s_valid_y;
   logic signed [ACC_W-1:0] s_data_y;
   logic                    s_ready_y;
   logic                    m_valid_z;
   logic signed [OUT_W-1:0] m_data_z;
   logic                    m_last_z;
   logic                    m_ready_z;
   logic                    relu_en;
   logic                    clear_ovf;
   logic                    ovf_sticky;
   logic                    frame_done;
   logic [LG_DEPTH:0]       occupancy;

   conv_out_buf #(
      .ACC_W(ACC_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LG_DEPTH(LG_DEPTH),
      .CONV_N(CONV_N), .LG_CONV_N(LG_CONV_N)
   ) dut (
      .clk(clk), .reset(reset),
      .s_valid_y(s_valid_y), .s_data_y(s_data_y), .s_ready_y(s_ready_y),
      .m_valid_z(m_valid_z), .m_data_z(m_data_z), .m_last_z(m_last_z), .m_ready_z(m_ready_z),
      .relu_en(relu_en), .clear_ovf(clear_ovf), .ovf_sticky(ovf_sticky),
      .frame_done(frame_done), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int data;
      bit last;
   } ent_t;

   // Reference model state
   ent_t q[$];
   ent_t seen[$];
   int   mbeat;
   bit   movf;
   bit   mfd;

   // Stimulus knobs applied at the start of each cycle
   bit   sv, rl, clr, mr;
   int   din;

   int   ncmp = 0;
   int   nerr = 0;
   int   pushes = 0;
   int   fd_cnt = 0;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void proc(input int d, input bit relu, output int o, output bit s);
      int v;
      int maxv;
      maxv = (1 << (OUT_W - 1)) - 1;
      v    = (relu && d < 0) ? 0 : d;
      s    = 1'b0;
      if (v > maxv) begin
         o = maxv; s = 1'b1;
      end else if (v < -maxv - 1) begin
         o = -maxv - 1; s = 1'b1;
      end else begin
         o = v;
      end
   endfunction

   task automatic cycle();
      bit   mpush, mpop, s;
      int   o;
      ent_t e;
      s_valid_y = sv; s_data_y = ACC_W'(din); relu_en = rl; clear_ovf = clr; m_ready_z = mr;
      #1;
      chk("s_ready", s_ready_y, q.size() != DEPTH);
      chk("m_valid", m_valid_z, q.size() != 0);
      chk("m_data", m_data_z, (q.size() != 0) ? q[0].data : 0);
      chk("m_last", m_last_z, (q.size() != 0) ? q[0].last : 1'b0);
      chk("occupancy", occupancy, q.size());
      chk("ovf_sticky", ovf_sticky, movf);
      chk("frame_done", frame_done, mfd);
      if (frame_done === 1'b1) fd_cnt++;
      mpush = sv && (q.size() != DEPTH);
      mpop  = mr && (q.size() != 0);
      mfd   = 1'b0;
      if (mpop) begin
         e = q.pop_front();
         seen.push_back(e);
         mfd = e.last;
      end
      proc(din, rl, o, s);
      if (mpush) begin
         e.data = o;
         e.last = (mbeat == CONV_N - 1);
         q.push_back(e);
         mbeat = (mbeat + 1) % CONV_N;
         pushes++;
      end
      if (mpush && s) movf = 1'b1;
      else if (clr)   movf = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      sv = 1'b0; mr = 1'b1;
      repeat (DEPTH + 2) cycle();
   endtask

   task automatic chk_data(input string tag, input int exp[$]);
      chk({tag, "_count"}, seen.size(), exp.size());
      for (int i = 0; i < exp.size() && i < seen.size(); i++) chk(tag, seen[i].data, exp[i]);
   endtask

   task automatic chk_last(input string tag, input bit exp[$]);
      for (int i = 0; i < exp.size() && i < seen.size(); i++) chk(tag, seen[i].last, exp[i]);
   endtask

   task automatic model_reset();
      q.delete();
      mbeat = 0; movf = 1'b0; mfd = 1'b0;
   endtask

   initial begin
      int sent[$];
      int target;
      int p0;
      int guard;

      reset = 1'b1; s_valid_y = 1'b0; s_data_y = '0; m_ready_z = 1'b0;
      relu_en = 1'b0; clear_ovf = 1'b0;
      sv = 0; rl = 0; clr = 0; mr = 0; din = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_ready", s_ready_y, 1);
      chk("rst_m_valid", m_valid_z, 0);
      chk("rst_m_last", m_last_z, 0);
      chk("rst_m_data", m_data_z, 0);
      chk("rst_occ", occupancy, 0);
      reset = 1'b0;
      #1;

      // Frame pass-through with saturation
      seen.delete(); fd_cnt = 0; mr = 1; sv = 1;
      sent = '{100, -7, 0, 40000, -40000};
      for (int i = 0; i < 5; i++) begin
         din = sent[i];
         cycle();
         if (i == 3) chk("ovf_after_4th", ovf_sticky, 1);
      end
      drain();
      chk_data("frame_data", '{100, -7, 0, 32767, -32768});
      chk_last("frame_last", '{0, 0, 0, 0, 1});
      chk("frame_done_count", fd_cnt, 1);

      clr = 1; cycle(); clr = 0;

      // ReLU path
      seen.delete(); rl = 1; sv = 1;
      sent = '{-5, -70000, 12};
      foreach (sent[i]) begin din = sent[i]; cycle(); end
      drain();
      rl = 0;
      chk_data("relu_data", '{0, 0, 12});
      chk("relu_no_ovf", ovf_sticky, 0);

      // Back-pressure to full, then release
      seen.delete(); sent.delete(); mr = 0; sv = 1;
      target = pushes + 6;
      din = int'($urandom_range(0, 60000)) - 30000;
      sent.push_back(din);
      guard = 0;
      while (pushes < target && guard < 40) begin
         if (guard == 6) begin
            chk("bp_full_occ", occupancy, 4);
            chk("bp_full_ready", s_ready_y, 0);
            mr = 1;
         end
         p0 = pushes;
         cycle();
         guard++;
         if (pushes != p0 && pushes < target) begin
            din = int'($urandom_range(0, 60000)) - 30000;
            sent.push_back(din);
         end
      end
      chk("bp_all_pushed", pushes, target);
      drain();
      chk_data("bp_order", sent);

      // Steady push/pop at occupancy 2
      seen.delete(); sent.delete(); mr = 0; sv = 1;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) mr = 1;
         din = int'($urandom_range(0, 60000)) - 30000;
         sent.push_back(din);
         cycle();
         if (i >= 2) chk("simul_occ", occupancy, 2);
      end
      drain();
      chk_data("simul_order", sent);

      // Clear versus saturating push in the same cycle
      clr = 1; sv = 1; din = 50000; mr = 1;
      cycle();
      chk("sticky_set_wins", ovf_sticky, 1);
      sv = 0;
      cycle();
      chk("sticky_cleared", ovf_sticky, 0);
      clr = 0;
      drain();

      // Reset in the middle of a frame
      mr = 0; sv = 1;
      repeat (3) begin din = int'($urandom_range(0, 2000)); cycle(); end
      sv = 0;
      reset = 1'b1;
      #1;
      chk("midrst_m_valid", m_valid_z, 0);
      chk("midrst_s_ready", s_ready_y, 1);
      chk("midrst_occ", occupancy, 0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      seen.delete(); mr = 1; sv = 1;
      repeat (5) begin din = int'($urandom_range(0, 2000)); cycle(); end
      drain();
      chk("midrst_count", seen.size(), 5);
      chk_last("midrst_last", '{0, 0, 0, 0, 1});

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         sv  = ($urandom_range(0, 3) != 0);
         mr  = ($urandom_range(0, 2) != 0);
         rl  = ($urandom_range(0, 3) == 0);
         clr = ($urandom_range(0, 7) == 0);
         din = int'($urandom_range(0, 160000)) - 80000;
         cycle();
      end
      clr = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
